// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite responder backed by a small bank of 32-bit registers.
// Write and read channels run as independent state machines. AW and W may
// arrive in either order or together. In-range accesses return OKAY and
// out-of-range accesses return SLVERR without touching any register.
module axi4lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    // write response channel
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    // read data channel
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // register bank
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // write path state
    w_state_e              w_state_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_held_q;
    logic                  w_held_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    // read path state
    r_state_e              r_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    // handshakes and held flags as they will be after this edge
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  aw_held_d;
    logic                  w_held_d;

    // address decode
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic [IDX_WIDTH-1:0]  aw_idx;
    logic [IDX_WIDTH-1:0]  ar_idx;

    assign aw_hs     = AWVALID && awready_q;
    assign w_hs      = WVALID  && wready_q;
    assign ar_hs     = ARVALID && arready_q;
    assign aw_held_d = aw_held_q || aw_hs;
    assign w_held_d  = w_held_q  || w_hs;

    assign aw_in_range = (awaddr_q < ADDR_LIMIT);
    assign ar_in_range = (ARADDR   < ADDR_LIMIT);
    assign aw_idx      = awaddr_q[IDX_WIDTH+1:2];
    assign ar_idx      = ARADDR[IDX_WIDTH+1:2];

    // Write FSM: collect AW and W in any order, execute once, then respond.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            // NOTE: non-blocking assignments only in clocked blocks, so every
            // register here sees the pre-edge value of every other register.
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q <= AWADDR;
                    end
                    if (w_hs) begin
                        wdata_q <= WDATA;
                        wstrb_q <= WSTRB;
                    end
                    aw_held_q <= aw_held_d;
                    w_held_q  <= w_held_d;
                    // each READY stays high only while its side has nothing held
                    awready_q <= !aw_held_d;
                    wready_q  <= !w_held_d;
                    if (aw_held_d && w_held_d) begin
                        w_state_q <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    bvalid_q  <= 1'b1;
                    bresp_q   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Register bank: byte-masked update during the single W_EXEC cycle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            // NOTE: the bank is small and must read back as zero after reset,
            // so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_state_q == W_EXEC && aw_in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb_q[b]) begin
                    regs_q[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: capture data on the AR handshake and hold it until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        // a same-cycle W_EXEC is not yet visible here, so a
                        // colliding read returns the pre-write value
                        rdata_q   <= ar_in_range ? regs_q[ar_idx] : '0;
                        rresp_q   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        rvalid_q  <= 1'b0;
                        rdata_q   <= '0;
                        rresp_q   <= RESP_OKAY;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Self-checking bench for axi4lite_slave_regfile. Expected B and R responses
// are queued when each transaction is issued and compared when the DUT
// presents them; a register-bank model supplies expected read data.
module tb_axi4lite_slave_regfile;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] model [8];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    axi4lite_slave_regfile #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (8)
    ) dut (
        .ACLK   (aclk),
        .ARESETN(aresetn),
        .AWADDR (awaddr),
        .AWVALID(awvalid),
        .AWREADY(awready),
        .WDATA  (wdata),
        .WSTRB  (wstrb),
        .WVALID (wvalid),
        .WREADY (wready),
        .BRESP  (bresp),
        .BVALID (bvalid),
        .BREADY (bready),
        .ARADDR (araddr),
        .ARVALID(arvalid),
        .ARREADY(arready),
        .RDATA  (rdata),
        .RRESP  (rresp),
        .RVALID (rvalid),
        .RREADY (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return (addr < 32'd32) ? 2'b00 : 2'b10;
    endfunction

    // Scoreboard: compare responses in the cycle before their handshake edge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (bvalid && bready) begin
                check("b_pending", 64'(b_q.size() > 0), 64'd1);
                if (b_q.size() > 0) check("b_resp", 64'(bresp), 64'(b_q.pop_front()));
            end
            if (rvalid && rready) begin
                check("r_pending", 64'(r_q.size() > 0), 64'd1);
                if (r_q.size() > 0) check("r_data_resp", 64'({rresp, rdata}), 64'(r_q.pop_front()));
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input bit wait_b);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_fire;
        bit w_fire;
        bit ready_bad = 0;
        int k = 0;
        int n = 0;
        b_q.push_back(exp_resp(addr));
        while (!(aw_done && w_done) && k < 100) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (k >= aw_dly);
            wvalid  = !w_done  && (k >= w_dly);
            aw_fire = awvalid && awready;
            w_fire  = wvalid  && wready;
            if ((aw_done && awready) || (w_done && wready)) ready_bad = 1;
            tick();
            k++;
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_handshakes", {62'd0, aw_done, w_done}, 64'd3);
        while (!bvalid && n < 20) begin
            if (awready || wready) ready_bad = 1;
            tick();
            n++;
        end
        check("b_latency", 64'(n + 1), 64'd2);
        if (wait_b) begin
            n = 0;
            while (bvalid && n < 50) begin
                if (awready || wready) ready_bad = 1;
                tick();
                n++;
            end
            check("b_done", 64'(bvalid), 64'd0);
            check("ready_after_b", {62'd0, awready, wready}, 64'd3);
        end
        check("ready_low_while_busy", 64'(ready_bad), 64'd0);
        if (addr < 32'd32) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[addr[4:2]][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic [31:0] exp_data;
        int n = 0;
        exp_data = (addr < 32'd32) ? model[addr[4:2]] : 32'h0;
        r_q.push_back({exp_resp(addr), exp_data});
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        check("r_latency", 64'(n + 1), 64'd1);
        n = 0;
        while (rvalid && n < 40) begin
            tick();
            n++;
        end
        check("r_idle_after", {29'd0, rvalid, arready, rdata}, {29'd0, 1'b0, 1'b1, 32'h0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stall_bad;
        logic [1:0] stall_resp;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        aresetn = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        // reset: everything low, READYs rise on the first edge after release
        tick();
        tick();
        check("reset_outputs", {bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready}, 64'd0);
        aresetn = 1'b1;
        check("ready_before_first_edge", {61'd0, awready, wready, arready}, 64'd0);
        tick();
        check("ready_first_edge", {61'd0, awready, wready, arready}, 64'd7);

        // AW and W together, then read back
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 1);
        do_read(32'h04);

        // W first, AW three cycles later, partial strobes over prior data
        do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, 1);
        do_write(32'h08, 32'h11223344, 4'h5, 3, 0, 1);
        do_read(32'h08);

        // AW first, W two cycles later
        do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 2, 1);
        do_read(32'h10);

        // out of range: SLVERR, no register (including aliased reg 0) changes
        do_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
        do_read(32'h20);
        do_read(32'h00);

        // zero strobes in range: OKAY, register unchanged
        do_write(32'h04, 32'h01234567, 4'h0, 0, 0, 1);
        do_read(32'h04);

        // B stalled for 5 cycles while a read completes on the other channel
        bready = 1'b0;
        do_write(32'h14, 32'h12345678, 4'hF, 0, 0, 0);
        stall_bad  = 0;
        stall_resp = bresp;
        fork
            do_read(32'h00);
            begin
                for (int i = 0; i < 5; i++) begin
                    if (!bvalid || bresp !== stall_resp || awready || wready) stall_bad = 1;
                    tick();
                end
            end
        join
        check("b_stall_stable", {63'd0, stall_bad}, 64'd0);
        check("b_stall_resp", 64'(stall_resp), 64'd0);
        bready = 1'b1;
        tick();
        check("b_after_stall", {61'd0, bvalid, awready, wready}, 64'd3);
        do_read(32'h14);

        // read colliding with W_EXEC returns the old value; next read the new
        do_write(32'h0C, 32'h5, 4'hF, 0, 0, 1);
        fork
            do_write(32'h0C, 32'h7, 4'hF, 0, 0, 1);
            begin
                tick();
                do_read(32'h0C);
            end
        join
        check("collide_model", 64'(model[3]), 64'h7);
        do_read(32'h0C);

        // reset after AW handshake, before W: transaction aborted
        awaddr  = 32'h04;
        awvalid = 1'b1;
        check("aw_ready_pre_abort", 64'(awready), 64'd1);
        tick();
        awvalid = 1'b0;
        check("aw_ready_held", 64'(awready), 64'd0);
        aresetn = 1'b0;
        #1;
        check("abort_outputs", {bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready}, 64'd0);
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("ready_after_abort", {61'd0, awready, wready, arready}, 64'd7);
        stall_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid) stall_bad = 1;
            tick();
        end
        check("no_stray_bvalid", {63'd0, stall_bad}, 64'd0);
        do_read(32'h04);
        do_read(32'h08);

        tick();
        check("b_queue_drained", 64'(b_q.size()), 64'd0);
        check("r_queue_drained", 64'(r_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
